// File: rtl/ysyx_22041211_core_ctrl_pkg.sv
// Shared types for the core sequencer: state encodings
// and the write-back / next-PC select codes.
package ysyx_22041211_core_ctrl_pkg;

  typedef enum logic [2:0] {
    CTRL_IDLE   = 3'd0,
    CTRL_FETCH  = 3'd1,
    CTRL_DECODE = 3'd2,
    CTRL_EXEC   = 3'd3,
    CTRL_MEM    = 3'd4,
    CTRL_WB     = 3'd5,
    CTRL_HALT   = 3'd6,
    CTRL_ERR    = 3'd7
  } ctrl_state_e;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;
  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_TGT = 1'b1;

endpackage

// File: rtl/ysyx_22041211_core_ctrl_if.sv
// IFU/LSU request/response handshake bundle seen by
// the core sequencer (master) and the memory side (slave).
interface ysyx_22041211_core_ctrl_if;

  logic ifu_req_o;
  logic ifu_rvalid_i;
  logic lsu_req_o;
  logic lsu_wen_o;
  logic lsu_rvalid_i;

  modport master (
    output ifu_req_o,
    output lsu_req_o,
    output lsu_wen_o,
    input  ifu_rvalid_i,
    input  lsu_rvalid_i
  );

  modport slave (
    input  ifu_req_o,
    input  lsu_req_o,
    input  lsu_wen_o,
    output ifu_rvalid_i,
    output lsu_rvalid_i
  );

endinterface

// File: rtl/ysyx_22041211_wait_timer.sv
// Bus wait counter; expired_o flags the TIMEOUT-th
// consecutive waiting cycle.
module ysyx_22041211_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_22041211_core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Define YSYX_22041211_PERF_CNT_EN for mcycle/minstret.
module ysyx_22041211_core_ctrl
  import ysyx_22041211_core_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 64
) (
  input  logic clk,
  input  logic rst,
  ysyx_22041211_core_ctrl_if.master bus,
  input  logic wd_i,
  input  logic is_load_i,
  input  logic is_store_i,
  input  logic jmp_flag_i,
  input  logic branch_taken_i,
  input  logic ebreak_i,
  output logic inst_latch_o,
  output logic reg_we_o,
  output logic wb_sel_o,
  output logic pc_we_o,
  output logic pc_sel_o,
  output logic halt_o,
  output logic err_o
`ifdef YSYX_22041211_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] mcycle_o,
  output logic [CNT_W-1:0] minstret_o
`endif
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;
  logic        pc_sel_q;
  logic        pc_sel_d;
  logic        wait_en;
  logic        expired;

  ysyx_22041211_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!wait_en),
    .en_i     (wait_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d       = state_q;
    pc_sel_d      = pc_sel_q;
    wait_en       = 1'b0;
    bus.ifu_req_o = 1'b0;
    bus.lsu_req_o = 1'b0;
    bus.lsu_wen_o = 1'b0;
    inst_latch_o  = 1'b0;
    reg_we_o      = 1'b0;
    wb_sel_o      = WB_SEL_ALU;
    pc_we_o       = 1'b0;
    pc_sel_o      = PC_SEL_SEQ;
    halt_o        = 1'b0;
    err_o         = 1'b0;
    unique case (state_q)
      CTRL_IDLE: state_d = CTRL_FETCH;
      CTRL_FETCH: begin
        bus.ifu_req_o = 1'b1;
        wait_en       = 1'b1;
        // a response on the expiring cycle still wins
        if (bus.ifu_rvalid_i) begin
          inst_latch_o = 1'b1;
          state_d      = CTRL_DECODE;
        end else if (expired) begin
          state_d = CTRL_ERR;
        end
      end
      CTRL_DECODE: begin
        state_d = ebreak_i ? CTRL_HALT : CTRL_EXEC;
      end
      CTRL_EXEC: begin
        pc_sel_d = (jmp_flag_i | branch_taken_i) ?
                   PC_SEL_TGT : PC_SEL_SEQ;
        state_d  = (is_load_i | is_store_i) ?
                   CTRL_MEM : CTRL_WB;
      end
      CTRL_MEM: begin
        bus.lsu_req_o = 1'b1;
        bus.lsu_wen_o = is_store_i;
        wait_en       = 1'b1;
        if (bus.lsu_rvalid_i) begin
          state_d = CTRL_WB;
        end else if (expired) begin
          state_d = CTRL_ERR;
        end
      end
      CTRL_WB: begin
        reg_we_o = wd_i & ~is_store_i;
        wb_sel_o = is_load_i ? WB_SEL_MEM : WB_SEL_ALU;
        pc_we_o  = 1'b1;
        pc_sel_o = pc_sel_q;
        state_d  = CTRL_FETCH;
      end
      CTRL_HALT: halt_o = 1'b1;
      CTRL_ERR:  err_o  = 1'b1;
      default:   state_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CTRL_IDLE;
      pc_sel_q <= PC_SEL_SEQ;
    end else begin
      state_q  <= state_d;
      pc_sel_q <= pc_sel_d;
    end
  end

`ifdef YSYX_22041211_PERF_CNT_EN
  logic [CNT_W-1:0] mcycle_q;
  logic [CNT_W-1:0] mcycle_d;
  logic [CNT_W-1:0] minstret_q;
  logic [CNT_W-1:0] minstret_d;

  always_comb begin
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;
    if (state_q != CTRL_HALT && state_q != CTRL_ERR) begin
      mcycle_d = mcycle_q + CNT_W'(1);
    end
    if (state_q == CTRL_WB) begin
      minstret_d = minstret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mcycle_o   = mcycle_q;
  assign minstret_o = minstret_q;
`endif

endmodule
